// File: rtl/udma_i2c_pad_filter.sv
// udma_i2c_pad_filter: synchronizes and glitch-filters the I2C pads and derives SCL edge, START/STOP, busy and arbitration events
module udma_i2c_pad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              periph_clk_i,
  input  logic              rst_i,
  input  logic [FILT_W-1:0] cfg_filt_len_i,
  input  logic              pad_scl_i,
  input  logic              pad_sda_i,
  input  logic              core_sda_drive_low_i,
  output logic              scl_o,
  output logic              sda_o,
  output logic              scl_rise_o,
  output logic              scl_fall_o,
  output logic              start_o,
  output logic              stop_o,
  output logic              bus_busy_o,
  output logic              arb_lost_o
);
  // Line index 0 is SCL, 1 is SDA.
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [FILT_W-1:0]      cnt_q  [2];
  logic [FILT_W-1:0]      cnt_d  [2];
  logic [1:0]             pad, s, f_q, f_d, prev_q, prev_d;
  logic                   busy_q, busy_d;
  assign pad = {pad_sda_i, pad_scl_i};
  assign s   = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
  // cnt >= L rather than == L so that shrinking L below a live count cannot lock the filter.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pad[i]};
      cnt_d[i]  = (s[i] == f_q[i] || cnt_q[i] >= cfg_filt_len_i) ? '0 : cnt_q[i] + 1'b1;
      f_d[i]    = (s[i] != f_q[i] && cnt_q[i] >= cfg_filt_len_i) ? s[i] : f_q[i];
    end
    prev_d = f_q;
    busy_d = start_o ? 1'b1 : stop_o ? 1'b0 : busy_q;
  end
  always_ff @(posedge periph_clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      f_q    <= '1;
      prev_q <= '1;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      f_q    <= f_d;
      prev_q <= prev_d;
      busy_q <= busy_d;
    end
  end
  assign scl_o      = f_q[0];
  assign sda_o      = f_q[1];
  assign scl_rise_o = f_q[0] & ~prev_q[0];
  assign scl_fall_o = ~f_q[0] & prev_q[0];
  assign start_o    = f_q[0] & prev_q[0] & prev_q[1] & ~f_q[1];
  assign stop_o     = f_q[0] & prev_q[0] & ~prev_q[1] & f_q[1];
  assign bus_busy_o = busy_q;
  assign arb_lost_o = scl_rise_o & busy_q & ~core_sda_drive_low_i & ~f_q[1];
endmodule
